// File: rtl/p_operand_fetch_if.sv
// Bundle of request, register-file read, writeback-observe and operand
// output signals for the PSIMD operand fetch block.
// slave  : the fetch block itself.
// master : the surrounding decode / register file / execution side.
interface p_operand_fetch_if #(
   parameter int REG_WIDTH = 64,
   parameter int OP_WIDTH  = 6
);
   // decode request
   logic                   req_valid;
   logic                   req_ready;
   logic [4:0]             req_rs1;
   logic [4:0]             req_rs2;
   logic [4:0]             req_rs3;
   logic [4:0]             req_rd;
   logic                   req_pair;
   logic [OP_WIDTH-1:0]    req_op;
   // register-file read ports
   logic [4:0]             rs1_address;
   logic [4:0]             rs2_address;
   logic [4:0]             rs3_address;
   logic [REG_WIDTH-1:0]   data1;
   logic [REG_WIDTH-1:0]   data2;
   logic [REG_WIDTH-1:0]   data3;
   // register-file write side, observed only
   logic                   wb_enable;
   logic [4:0]             wb_address;
   // operand output to execution
   logic                   op_valid;
   logic                   op_ready;
   logic [2*REG_WIDTH-1:0] op_a;
   logic [2*REG_WIDTH-1:0] op_b;
   logic [2*REG_WIDTH-1:0] op_c;
   logic [4:0]             op_rd;
   logic [OP_WIDTH-1:0]    op_op;

   modport slave (
      input  req_valid, req_rs1, req_rs2, req_rs3, req_rd, req_pair, req_op,
      input  data1, data2, data3, wb_enable, wb_address, op_ready,
      output req_ready, rs1_address, rs2_address, rs3_address,
      output op_valid, op_a, op_b, op_c, op_rd, op_op
   );

   modport master (
      output req_valid, req_rs1, req_rs2, req_rs3, req_rd, req_pair, req_op,
      output data1, data2, data3, wb_enable, wb_address, op_ready,
      input  req_ready, rs1_address, rs2_address, rs3_address,
      input  op_valid, op_a, op_b, op_c, op_rd, op_op
   );
endinterface

// File: rtl/p_operand_fetch.sv
// PSIMD operand fetch: sequences register-file reads for one instruction at
// a time, reading 128-bit pair sources as rs (low) then rs+1 (high), and
// presents up to three assembled operands under valid/ready.
// Optional macro PSIMD_SCOREBOARD_EN enables the busy scoreboard and the
// read-after-write / write-after-write stall in FETCH_LO.
// rst_n is active-high and synchronous (historical name).
module p_operand_fetch #(
   parameter int REG_WIDTH = 64,
   parameter int OP_WIDTH  = 6
) (
   input logic             clk,
   input logic             rst_n,
   p_operand_fetch_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, OUT} state_t;

   state_t                 state;
   logic                   req_ready_q;
   logic                   op_valid_q;
   logic [4:0]             rs1_q, rs2_q, rs3_q, rd_q;
   logic                   pair_q;
   logic [OP_WIDTH-1:0]    op_q;
   logic [2*REG_WIDTH-1:0] a_q, b_q, c_q;
   logic                   hazard;

   // High-half address of a pair; register 31 has no partner, so the
   // address stays at 31 instead of wrapping to 0.
   function automatic logic [4:0] hi_addr(input logic [4:0] rs);
      return (rs == 5'd31) ? rs : rs + 5'd1;
   endfunction

   // High-half read data; forced to zero when the pair base is 31.
   function automatic logic [REG_WIDTH-1:0] hi_data(input logic [4:0] rs,
                                                    input logic [REG_WIDTH-1:0] d);
      return (rs == 5'd31) ? '0 : d;
   endfunction

`ifdef PSIMD_SCOREBOARD_EN
   logic [31:0] busy;
   logic [31:0] busy_set;
   logic [31:0] busy_clr;

   // Mask covering idx and, unless idx is 31, idx+1.
   function automatic logic [31:0] pair_mask(input logic [4:0] idx, input logic with_hi);
      logic [31:0] m;
      m = 32'd1 << idx;
      if (with_hi && idx != 5'd31) m = m | (32'd1 << (idx + 5'd1));
      return m;
   endfunction

   // Hazard against registered busy: sources (plus partners for pairs) and
   // the destination pair.
   always_comb begin
      hazard = |(busy & (pair_mask(rs1_q, pair_q) | pair_mask(rs2_q, pair_q) |
                         pair_mask(rs3_q, pair_q) | pair_mask(rd_q, 1'b1)));
   end

   // Set on issue handshake, clear on writeback.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (state == OUT && bus.op_ready) busy_set = pair_mask(rd_q, 1'b1);
      if (bus.wb_enable) busy_clr = pair_mask(bus.wb_address, 1'b1);
   end

   // Scoreboard register; a set beats a clear on the same bit.
   always_ff @(posedge clk) begin
      if (rst_n) busy <= '0;
      else       busy <= (busy & ~busy_clr) | busy_set;
   end
`else
   logic wb_unused;

   // Ordering is left to software/upstream; writeback is not observed.
   always_comb begin
      hazard    = 1'b0;
      wb_unused = ^{bus.wb_enable, bus.wb_address};
   end
`endif

   // Read addresses follow the state: captured sources in FETCH_LO,
   // their partners in FETCH_HI, zero otherwise.
   always_comb begin
      bus.rs1_address = 5'd0;
      bus.rs2_address = 5'd0;
      bus.rs3_address = 5'd0;
      if (state == FETCH_LO) begin
         bus.rs1_address = rs1_q;
         bus.rs2_address = rs2_q;
         bus.rs3_address = rs3_q;
      end else if (state == FETCH_HI) begin
         bus.rs1_address = hi_addr(rs1_q);
         bus.rs2_address = hi_addr(rs2_q);
         bus.rs3_address = hi_addr(rs3_q);
      end
   end

   // Fetch sequencer with registered handshake outputs and operand assembly.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state       <= IDLE;
         req_ready_q <= 1'b1;
         op_valid_q  <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rs3_q       <= '0;
         rd_q        <= '0;
         pair_q      <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  rs1_q       <= bus.req_rs1;
                  rs2_q       <= bus.req_rs2;
                  rs3_q       <= bus.req_rs3;
                  rd_q        <= bus.req_rd;
                  pair_q      <= bus.req_pair;
                  op_q        <= bus.req_op;
                  req_ready_q <= 1'b0;
                  state       <= FETCH_LO;
               end
            end
            FETCH_LO: begin
               if (!hazard) begin
                  a_q[REG_WIDTH-1:0] <= bus.data1;
                  b_q[REG_WIDTH-1:0] <= bus.data2;
                  c_q[REG_WIDTH-1:0] <= bus.data3;
                  if (pair_q) begin
                     state <= FETCH_HI;
                  end else begin
                     a_q[2*REG_WIDTH-1:REG_WIDTH] <= '0;
                     b_q[2*REG_WIDTH-1:REG_WIDTH] <= '0;
                     c_q[2*REG_WIDTH-1:REG_WIDTH] <= '0;
                     op_valid_q <= 1'b1;
                     state      <= OUT;
                  end
               end
            end
            FETCH_HI: begin
               a_q[2*REG_WIDTH-1:REG_WIDTH] <= hi_data(rs1_q, bus.data1);
               b_q[2*REG_WIDTH-1:REG_WIDTH] <= hi_data(rs2_q, bus.data2);
               c_q[2*REG_WIDTH-1:REG_WIDTH] <= hi_data(rs3_q, bus.data3);
               op_valid_q <= 1'b1;
               state      <= OUT;
            end
            OUT: begin
               if (bus.op_ready) begin
                  op_valid_q  <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               op_valid_q  <= 1'b0;
               req_ready_q <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   // Output port wiring.
   always_comb begin
      bus.req_ready = req_ready_q;
      bus.op_valid  = op_valid_q;
      bus.op_a      = a_q;
      bus.op_b      = b_q;
      bus.op_c      = c_q;
      bus.op_rd     = rd_q;
      bus.op_op     = op_q;
   end

endmodule

// File: tb/tb_p_operand_fetch.sv
// Directed bench for p_operand_fetch: reset state, non-pair and pair fetch
// latency and data, no-wrap at register 31, output hold under back-pressure,
// scoreboard stall/release (or its absence in the default build), and reset
// in the middle of a pair fetch.
module tb_p_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] regs [32];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          lat;

   p_operand_fetch_if #(.REG_WIDTH(64), .OP_WIDTH(6)) bus ();

   p_operand_fetch #(.REG_WIDTH(64), .OP_WIDTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Register-file model: combinational read.
   assign bus.data1 = regs[bus.rs1_address];
   assign bus.data2 = regs[bus.rs2_address];
   assign bus.data3 = regs[bus.rs3_address];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request in IDLE; returns #1 after the accept edge.
   task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] r3,
                        input logic [4:0] rd, input logic pair, input logic [5:0] op);
      bus.req_valid = 1'b1;
      bus.req_rs1   = r1;
      bus.req_rs2   = r2;
      bus.req_rs3   = r3;
      bus.req_rd    = rd;
      bus.req_pair  = pair;
      bus.req_op    = op;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Edges after the accept edge until op_valid is seen; the consumer
   // samples it on edge number lat+1 after accept.
   task automatic wait_valid(output int l);
      l = 0;
      while (bus.op_valid !== 1'b1 && l < 20) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic handshake();
      bus.op_ready = 1'b1;
      @(posedge clk); #1;
      bus.op_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 64'hF000_0000_0000_0000 | 64'(i);
      regs[0]  = 64'hDEAD_BEEF;
      regs[3]  = 64'hA;
      regs[4]  = 64'hB;
      regs[5]  = 64'hC;
      regs[6]  = 64'h1111;
      regs[7]  = 64'h2222;
      regs[10] = 64'hAAAA;
      regs[11] = 64'hBBBB;
      regs[12] = 64'hCCCC;
      regs[31] = 64'h3131;

      bus.req_valid  = 1'b0;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.req_rs3    = '0;
      bus.req_rd     = '0;
      bus.req_pair   = 1'b0;
      bus.req_op     = '0;
      bus.wb_enable  = 1'b0;
      bus.wb_address = '0;
      bus.op_ready   = 1'b0;
      rst_n          = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;

      // reset state
      check("rst_op_valid",  128'(bus.op_valid),    128'd0);
      check("rst_req_ready", 128'(bus.req_ready),   128'd1);
      check("rst_addr1",     128'(bus.rs1_address), 128'd0);
      check("rst_op_a",      bus.op_a,              128'd0);
      check("rst_op_op",     128'(bus.op_op),       128'd0);

      // non-pair fetch
      issue(5'd3, 5'd4, 5'd5, 5'd1, 1'b0, 6'h11);
      check("np_addr1", 128'(bus.rs1_address), 128'd3);
      check("np_addr2", 128'(bus.rs2_address), 128'd4);
      check("np_addr3", 128'(bus.rs3_address), 128'd5);
      check("np_valid_early", 128'(bus.op_valid), 128'd0);
      wait_valid(lat);
      check("np_latency", 128'(lat + 1), 128'd2);
      check("np_op_a", bus.op_a, 128'hA);
      check("np_op_b", bus.op_b, 128'hB);
      check("np_op_c", bus.op_c, 128'hC);
      check("np_op_op", 128'(bus.op_op), 128'h11);
      check("np_op_rd", 128'(bus.op_rd), 128'd1);
      check("np_req_ready_out", 128'(bus.req_ready), 128'd0);
      handshake();
      check("np_valid_drop", 128'(bus.op_valid), 128'd0);
      check("np_req_ready_back", 128'(bus.req_ready), 128'd1);

      // pair fetch
      issue(5'd6, 5'd10, 5'd11, 5'd12, 1'b1, 6'h22);
      check("pr_addr_lo", 128'(bus.rs1_address), 128'd6);
      @(posedge clk); #1;
      check("pr_addr_hi", 128'(bus.rs1_address), 128'd7);
      check("pr_valid_hi", 128'(bus.op_valid), 128'd0);
      @(posedge clk); #1;
      check("pr_valid_out", 128'(bus.op_valid), 128'd1);
      check("pr_op_a", bus.op_a, {64'h2222, 64'h1111});
      check("pr_op_b", bus.op_b, {64'hBBBB, 64'hAAAA});
      check("pr_op_c", bus.op_c, {64'hCCCC, 64'hBBBB});
      handshake();

      // pair at register 31: no wrap, high half zero; then back-pressure
      issue(5'd31, 5'd14, 5'd15, 5'd16, 1'b1, 6'h33);
      check("r31_addr_lo", 128'(bus.rs1_address), 128'd31);
      @(posedge clk); #1;
      check("r31_addr_hi", 128'(bus.rs1_address), 128'd31);
      @(posedge clk); #1;
      check("r31_valid", 128'(bus.op_valid), 128'd1);
      check("r31_op_a", bus.op_a, {64'h0, 64'h3131});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 128'(bus.op_valid), 128'd1);
         check("hold_op_a", bus.op_a, {64'h0, 64'h3131});
         check("hold_op_op", 128'(bus.op_op), 128'h33);
         check("hold_req_ready", 128'(bus.req_ready), 128'd0);
      end
      handshake();
      check("hold_release_ready", 128'(bus.req_ready), 128'd1);

      // scoreboard: write rd=8 pair, then read r9
      issue(5'd20, 5'd21, 5'd22, 5'd8, 1'b0, 6'h08);
      wait_valid(lat);
      handshake();
      issue(5'd23, 5'd9, 5'd24, 5'd25, 1'b0, 6'h09);
`ifdef PSIMD_SCOREBOARD_EN
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("sb_stall_valid", 128'(bus.op_valid), 128'd0);
         check("sb_stall_addr2", 128'(bus.rs2_address), 128'd9);
      end
      bus.wb_enable  = 1'b1;
      bus.wb_address = 5'd8;
      @(posedge clk); #1;
      bus.wb_enable  = 1'b0;
      check("sb_clear_edge_valid", 128'(bus.op_valid), 128'd0);
      @(posedge clk); #1;
      check("sb_release_valid", 128'(bus.op_valid), 128'd1);
`else
      wait_valid(lat);
      check("nosb_latency", 128'(lat + 1), 128'd2);
`endif
      check("sb_op_b", bus.op_b, {64'h0, regs[9]});
      handshake();
      // r8 and r9 readable without stall
      issue(5'd8, 5'd9, 5'd3, 5'd27, 1'b0, 6'h0A);
      wait_valid(lat);
      check("sb_free_latency", 128'(lat + 1), 128'd2);
      check("sb_free_op_a", bus.op_a, {64'h0, regs[8]});
      handshake();

      // reset during FETCH_HI
      issue(5'd3, 5'd4, 5'd5, 5'd29, 1'b1, 6'h3F);
      @(posedge clk); #1;
      check("rh_in_fetch_hi", 128'(bus.rs1_address), 128'd4);
      rst_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      check("rh_op_valid", 128'(bus.op_valid), 128'd0);
      check("rh_req_ready", 128'(bus.req_ready), 128'd1);
      check("rh_addr1", 128'(bus.rs1_address), 128'd0);
      check("rh_op_a", bus.op_a, 128'd0);
      check("rh_op_rd", 128'(bus.op_rd), 128'd0);
      // every previously busy register is readable immediately
      issue(5'd1, 5'd12, 5'd25, 5'd2, 1'b0, 6'h01);
      wait_valid(lat);
      check("rh_busy_clear_latency", 128'(lat + 1), 128'd2);
      check("rh_op_a_after", bus.op_a, {64'h0, regs[1]});
      handshake();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/p_operand_fetch.md
Name: p_operand_fetch

Overview:
- Read-side sequencer for the PSIMD 32-entry register file. It accepts one decoded instruction at a time and drives the three combinational read addresses.
- For 128-bit "pair" operands it reads each source over two cycles: low half at rs, high half at rs+1. This matches the register-file write side, which always writes rd and rd+1.
- It assembles up to three operands and presents them to the execution unit under valid/ready.
- It keeps a busy scoreboard so it never reads a register with a write still outstanding.

Parameters:
- REG_WIDTH, 64, width of one register and of each register-file read port.
- OP_WIDTH, 6, width of the opcode tag passed through unchanged.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-high reset; the name is historical and the polarity is high.
- req_valid  input  1  decode has a request.
- req_ready  output  1  block can accept a request.
- req_rs1, req_rs2, req_rs3  input  5 each  source register indices.
- req_rd  input  5  destination pair base index.
- req_pair  input  1  1 = sources are 128-bit register pairs.
- req_op  input  OP_WIDTH  opcode tag.
- rs1_address, rs2_address, rs3_address  output  5 each  register-file read addresses.
- data1, data2, data3  input  REG_WIDTH each  register-file read data, valid in the same cycle as the address.
- wb_enable  input  1  register-file write strobe, observed.
- wb_address  input  5  register-file write base, observed.
- op_valid  output  1  operands ready.
- op_ready  input  1  execution unit accepts.
- op_a, op_b, op_c  output  2*REG_WIDTH each  operands {hi, lo}.
- op_rd  output  5  captured req_rd.
- op_op  output  OP_WIDTH  captured req_op.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. When rst_n=1 at a clk edge:
  - state returns to IDLE;
  - busy[31:0] clears;
  - op_valid=0;
  - op_a/op_b/op_c/op_rd/op_op and all captured fields go to 0;
  - read addresses go to 0.
  - Reset mid-fetch or mid-OUT discards the instruction; no scoreboard bit is set.
- FSM has four states: IDLE, FETCH_LO, FETCH_HI, OUT.
- IDLE:
  - req_ready=1; the addresses drive 0.
  - On req_valid&&req_ready, capture rs1..3, rd, pair, op and go to FETCH_LO.
- FETCH_LO:
  - Drive the captured rs1..3 on the addresses.
  - Hazard = any of the following bits is set: busy[rsN]; busy[rsN+1] when pair and rsN<31; busy[rd]; busy[rd+1] when rd<31.
  - On hazard, hold in FETCH_LO.
  - With no hazard, latch data1..3 into the low halves. Go to FETCH_HI if pair, else clear the high halves and go to OUT.
- FETCH_HI:
  - Drive rsN+1 on the addresses.
  - Latch data1..3 into the high halves; a high half is forced 0 when rsN=31 (no wrap).
  - Go to OUT.
- OUT:
  - op_valid=1; the outputs are stable until the handshake.
  - On op_ready, go to IDLE and set busy[rd], plus busy[rd+1] if rd<31.
  - op_ready is ignored outside OUT.
- Latency from the accept edge to op_valid, with no hazard: 2 cycles non-pair, 3 cycles pair. Throughput is one instruction per 3 or 4 cycles.
- Scoreboard:
  - wb_enable clears busy[wb_address] and busy[wb_address+1], the latter only if wb_address<31.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - The hazard check uses registered busy; a writeback's data becomes readable the cycle after its clearing edge.
- Register 0 is an ordinary register; it is not hardwired.

Optional Feature:
- Macro: PSIMD_SCOREBOARD_EN.
- Defined: the busy scoreboard and hazard stall operate as described above.
- Undefined:
  - busy is not implemented; the hazard term is constant 0, so FETCH_LO always completes in one cycle;
  - wb_enable and wb_address are unused;
  - software or the upstream pipeline is responsible for ordering.

Test Plan:
- Reset, then req rs1=3, rs2=4, rs3=5, pair=0, op=0x11 with the register file holding R3=0xA, R4=0xB, R5=0xC -> op_valid rises 2 cycles after accept; op_a=0x...0_000A, op_b=0x...0_000B, op_c=0x...0_000C with upper 64 bits 0; op_op=0x11.
- Pair req rs1=6, R6=0x1111, R7=0x2222 -> rs1_address shows 6 then 7; op_a={0x2222, 0x1111}; op_valid rises 3 cycles after accept.
- Pair req rs1=31 -> the high half of op_a is 0; rs1_address is never driven to 0 in FETCH_HI as a wrap.
- Scoreboard (PSIMD_SCOREBOARD_EN):
  - issue with rd=8 and complete the handshake; the next req with rs2=9 stalls in FETCH_LO;
  - wb_enable with wb_address=8 -> op_valid follows 2 cycles after the clear;
  - busy[8] and busy[9] are both 0.
- Hold op_ready=0 for 5 cycles in OUT -> op_valid stays 1, outputs unchanged, req_ready=0; release -> req_ready=1 the next cycle.
- Assert rst_n during FETCH_HI -> the next cycle is IDLE with op_valid=0, all busy bits 0, and req_ready=1.
